// File: rtl/plic_pkg.sv
// Shared constants, bus bundles and register-file layout for the PLIC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package plic_pkg;

  localparam int PLIC_NSRC   = 8;
  localparam int PLIC_PRIO_W = 3;
  localparam int PLIC_ID_W   = 5;

  // Register offsets within the 22-bit decoded window
  localparam logic [21:0] OFS_PRIO      = 22'h000000;
  localparam logic [21:0] OFS_PENDING   = 22'h001000;
  localparam logic [21:0] OFS_ENABLE    = 22'h002000;
  localparam logic [21:0] OFS_THRESHOLD = 22'h200000;
  localparam logic [21:0] OFS_CLAIM     = 22'h200004;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } plic_in_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } plic_out_type;

  // Index 0 of every per-source field is the "no interrupt" ID and stays 0
  typedef struct packed {
    logic [PLIC_NSRC:0][PLIC_PRIO_W-1:0] prio;
    logic [PLIC_NSRC:0]                  pending;
    logic [PLIC_NSRC:0]                  enable;
    logic [PLIC_NSRC:0]                  inflight;
    logic [PLIC_PRIO_W-1:0]              threshold;
  } plic_reg_type;

  localparam plic_reg_type init_plic_reg = '0;

  // Word-granular match of a decoded offset against a register offset
  function automatic logic is_reg(input logic [21:0] ofs, input logic [21:0] reg_ofs);
    return ofs[21:2] == reg_ofs[21:2];
  endfunction

endpackage

// File: rtl/plic_arbiter.sv
// Picks the highest-priority enabled pending source above threshold.
// Latency: purely combinational.
// Backpressure: none.
module plic_arbiter #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic [NSRC:0]             pending_i,
  input  logic [NSRC:0]             enable_i,
  input  logic [NSRC:0][PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         threshold_i,
  output logic [4:0]                best_id_o,
  output logic [PRIO_W-1:0]         max_prio_o
);

  logic [NSRC:0] cand;
  logic          unused_id0;

  // ID 0 never takes part in arbitration
  assign unused_id0 = pending_i[0] ^ enable_i[0] ^ (^prio_i[0]);

  // Candidate mask: pending, enabled and strictly above threshold
  always_comb begin
    cand = '0;
    for (int i = 1; i <= NSRC; i++) begin
      cand[i] = pending_i[i] & enable_i[i] & (prio_i[i] > threshold_i);
    end
  end

  // Scan from the highest ID down; >= lets a lower ID take over on a tie
  always_comb begin
    best_id_o  = '0;
    max_prio_o = '0;
    for (int i = NSRC; i >= 1; i--) begin
      if (cand[i] && (prio_i[i] >= max_prio_o)) begin
        best_id_o  = 5'(i);
        max_prio_o = prio_i[i];
      end
    end
  end

endmodule

// File: rtl/plic.sv
// Platform-level interrupt controller for one M-mode hart: gateway, arbiter, claim/complete.
// Latency: bus response one cycle after acceptance; irq_src to meip is three edges.
// Backpressure: one access in flight; mem_valid must be held until the mem_ready pulse.
module plic
  import plic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PLIC_NSRC-1:0] irq_src,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ready,
  output logic                 meip
);

  localparam int NSRC   = PLIC_NSRC;
  localparam int PRIO_W = PLIC_PRIO_W;

  plic_in_type  bus_in;
  plic_out_type bus_out;

  plic_reg_type r_q, r_d;
  logic [NSRC-1:0] irq_q;
  bus_state_e      state_q, state_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            meip_q, meip_d;

  logic [4:0]        best_id;
  logic [PRIO_W-1:0] max_prio;

  logic        accept, is_read, is_write;
  logic [21:0] ofs;
  logic        prio_sel, pend_sel, en_sel, thr_sel, claim_sel;
  logic [9:0]  prio_idx;
  logic [4:0]  cpl_id;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign bus_in = '{valid: mem_valid, instr: mem_instr, addr: mem_addr,
                    wdata: mem_wdata, wstrb: mem_wstrb};

  // Fetches are acknowledged but never touch state; any nonzero strobe is a full write
  assign accept   = bus_in.valid && (state_q == BUS_IDLE);
  assign is_read  = accept && !bus_in.instr && (bus_in.wstrb == 4'b0000);
  assign is_write = accept && !bus_in.instr && (bus_in.wstrb != 4'b0000);

  assign ofs       = bus_in.addr[21:0];
  assign prio_sel  = (ofs[21:12] == OFS_PRIO[21:12]);
  assign prio_idx  = ofs[11:2];
  assign pend_sel  = is_reg(ofs, OFS_PENDING);
  assign en_sel    = is_reg(ofs, OFS_ENABLE);
  assign thr_sel   = is_reg(ofs, OFS_THRESHOLD);
  assign claim_sel = is_reg(ofs, OFS_CLAIM);
  assign cpl_id    = bus_in.wdata[4:0];

  assign unused_ok = ^{bus_in.addr[31:22], bus_in.addr[1:0],
                       bus_in.wdata[31:NSRC+1], max_prio};

  plic_arbiter #(
    .NSRC   (NSRC),
    .PRIO_W (PRIO_W)
  ) u_arbiter (
    .pending_i   (r_q.pending),
    .enable_i    (r_q.enable),
    .prio_i      (r_q.prio),
    .threshold_i (r_q.threshold),
    .best_id_o   (best_id),
    .max_prio_o  (max_prio)
  );

  // Read mux; the claim word returns the arbiter result seen at acceptance
  always_comb begin
    rd_val = '0;
    if (prio_sel) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (prio_idx == 10'(i)) rd_val = 32'(r_q.prio[i]);
      end
    end else if (pend_sel) begin
      rd_val = 32'(r_q.pending);
    end else if (en_sel) begin
      rd_val = 32'(r_q.enable);
    end else if (thr_sel) begin
      rd_val = 32'(r_q.threshold);
    end else if (claim_sel) begin
      rd_val = 32'(best_id);
    end
  end

  // Bus FSM next state: one-cycle response, rdata held at 0 outside the response
  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    case (state_q)
      BUS_IDLE: begin
        if (accept) begin
          state_d = BUS_RESP;
          rdata_d = is_read ? rd_val : 32'd0;
        end
      end
      BUS_RESP: state_d = BUS_IDLE;
    endcase
  end

  // Register file next state: gateway first, then claim (which overrides it), then writes
  always_comb begin
    r_d    = r_q;
    meip_d = (best_id != 5'd0);

    for (int i = 1; i <= NSRC; i++) begin
      if (irq_q[i-1] && !r_q.pending[i] && !r_q.inflight[i]) r_d.pending[i] = 1'b1;
    end

    if (is_read && claim_sel && (best_id != 5'd0)) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (best_id == 5'(i)) begin
          r_d.pending[i]  = 1'b0;
          r_d.inflight[i] = 1'b1;
        end
      end
    end

    if (is_write) begin
      if (prio_sel) begin
        for (int i = 1; i <= NSRC; i++) begin
          if (prio_idx == 10'(i)) r_d.prio[i] = bus_in.wdata[PRIO_W-1:0];
        end
      end
      if (en_sel)  r_d.enable    = {bus_in.wdata[NSRC:1], 1'b0};
      if (thr_sel) r_d.threshold = bus_in.wdata[PRIO_W-1:0];
      if (claim_sel) begin
        for (int i = 1; i <= NSRC; i++) begin
          if ((cpl_id == 5'(i)) && r_q.inflight[i]) r_d.inflight[i] = 1'b0;
        end
      end
    end
  end

  // State registers; reset drops any access in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q     <= init_plic_reg;
      irq_q   <= '0;
      state_q <= BUS_IDLE;
      rdata_q <= '0;
      meip_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      irq_q   <= irq_src;
      state_q <= state_d;
      rdata_q <= rdata_d;
      meip_q  <= meip_d;
    end
  end

  assign bus_out.ready = (state_q == BUS_RESP);
  assign bus_out.rdata = rdata_q;

  assign mem_ready = bus_out.ready;
  assign mem_rdata = bus_out.rdata;
  assign meip      = meip_q;

endmodule

// File: tb/tb_plic.sv
// Directed bench for plic: bus reads/writes via a scoreboard queue, meip timing checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_plic;

  localparam logic [31:0] A_PEND  = 32'h0000_1000;
  localparam logic [31:0] A_EN    = 32'h0000_2000;
  localparam logic [31:0] A_TH    = 32'h0020_0000;
  localparam logic [31:0] A_CLAIM = 32'h0020_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        meip;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       tag_q[$];

  plic dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .meip      (meip)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prio_a(input int id);
    return 32'(4 * id);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access; expected read data goes through the scoreboard queue
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic instr, input bit chk, input logic [31:0] exp,
                      input string tag);
    int          lat;
    logic [31:0] e;
    bit          c;
    string       t;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_instr = instr;
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    tag_q.push_back(tag);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 8);
    mem_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd1);
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    t = tag_q.pop_front();
    if (c) check(t, mem_rdata, e);
    @(posedge clk);
    #1;
    check({tag, "_rdy_drop"}, {31'b0, mem_ready}, 32'd0);
    check({tag, "_rdata_idle"}, mem_rdata, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    xfer(a, 32'd0, 4'b0000, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input string tag);
    xfer(a, wd, 4'b1111, 1'b0, 1'b0, 32'd0, tag);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_meip", {31'b0, meip}, 32'd0);
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int id = 0; id <= 9; id++) rd(prio_a(id), 32'd0, $sformatf("rst_prio%0d", id));
    rd(A_PEND,  32'd0, "rst_pend");
    rd(A_EN,    32'd0, "rst_en");
    rd(A_TH,    32'd0, "rst_th");
    rd(A_CLAIM, 32'd0, "rst_claim");
    rd(32'h0000_3000, 32'd0, "unmapped_rd");
    wr(32'h0000_3000, 32'hFFFF_FFFF, "unmapped_wr");
    rd(32'h0020_0008, 32'd0, "unmapped_rd2");

    // Register access and masking
    wr(prio_a(0), 32'd5, "prio0_wr");
    rd(prio_a(0), 32'd0, "prio0_ro");
    wr(prio_a(3), 32'hFF, "prio3_wide");
    rd(prio_a(3), 32'd7, "prio3_mask");
    wr(prio_a(3), 32'd2, "prio3_wr");
    rd(prio_a(3), 32'd2, "prio3_rd");
    wr(A_EN, 32'hFFFF_FFFF, "en_all");
    rd(A_EN, 32'h0000_01FE, "en_mask");
    xfer(A_EN, 32'h8, 4'b0001, 1'b0, 1'b0, 32'd0, "en_partial");
    rd(A_EN, 32'h8, "en_rd");
    wr(A_TH, 32'd1, "th_wr");
    rd(A_TH, 32'd1, "th_rd");
    wr(A_PEND, 32'hFF, "pend_wr");
    rd(A_PEND, 32'd0, "pend_ro");

    // One-cycle pulse on source 3: meip after three edges
    @(negedge clk);
    irq_src = 8'h04;
    @(posedge clk); #1;
    irq_src = 8'h00;
    check("pulse_e1", {31'b0, meip}, 32'd0);
    @(posedge clk); #1;
    check("pulse_e2", {31'b0, meip}, 32'd0);
    @(posedge clk); #1;
    check("pulse_e3", {31'b0, meip}, 32'd1);
    rd(A_CLAIM, 32'd3, "claim3");
    check("meip_after_claim3", {31'b0, meip}, 32'd0);
    rd(A_PEND, 32'd0, "pend_after_claim3");
    wr(A_CLAIM, 32'd3, "cpl3");

    // Equal priorities resolve to the lowest ID
    wr(prio_a(2), 32'd4, "prio2_wr");
    wr(prio_a(5), 32'd4, "prio5_wr");
    wr(prio_a(6), 32'd4, "prio6_wr");
    wr(A_EN, 32'h64, "en_256");
    @(negedge clk);
    irq_src = 8'h32;
    repeat (3) @(posedge clk);
    rd(A_PEND, 32'h64, "pend_256");
    rd(A_CLAIM, 32'd2, "tie_claim2");
    rd(A_CLAIM, 32'd5, "tie_claim5");
    rd(A_CLAIM, 32'd6, "tie_claim6");
    rd(A_CLAIM, 32'd0, "tie_claim0");
    rd(A_PEND, 32'd0, "no_repend_inflight");
    check("meip_all_claimed", {31'b0, meip}, 32'd0);

    // Completes that must be ignored
    wr(A_CLAIM, 32'd0, "cpl_id0");
    wr(A_CLAIM, 32'd9, "cpl_id9");
    wr(A_CLAIM, 32'd4, "cpl_id4");
    rd(A_PEND, 32'd0, "pend_after_bad_cpl");
    rd(A_CLAIM, 32'd0, "claim_after_bad_cpl");

    // Completing 2 with its line still high re-pends it
    wr(A_CLAIM, 32'd2, "cpl2");
    rd(A_PEND, 32'h04, "repend2");
    rd(A_CLAIM, 32'd2, "reclaim2");
    @(negedge clk);
    irq_src = 8'h00;
    wr(A_CLAIM, 32'd2, "cpl2b");
    wr(A_CLAIM, 32'd5, "cpl5");
    wr(A_CLAIM, 32'd6, "cpl6");
    rd(A_PEND, 32'd0, "pend_all_low");

    // Threshold gating
    wr(A_TH, 32'd4, "th4");
    wr(prio_a(1), 32'd4, "prio1_wr");
    wr(A_EN, 32'h82, "en_17");
    @(negedge clk);
    irq_src = 8'h01;
    repeat (4) @(posedge clk);
    #1;
    check("meip_th_block", {31'b0, meip}, 32'd0);
    rd(A_PEND, 32'h02, "pend1_th");
    wr(A_TH, 32'd3, "th3");
    check("meip_th_open", {31'b0, meip}, 32'd1);

    // Higher priority beats lower ID
    wr(prio_a(7), 32'd6, "prio7_wr");
    @(negedge clk);
    irq_src = 8'h41;
    repeat (3) @(posedge clk);
    rd(A_CLAIM, 32'd7, "claim7_first");
    rd(A_CLAIM, 32'd1, "claim1_second");
    rd(A_CLAIM, 32'd0, "claim_empty");

    // Instruction fetches read 0 and do not write
    xfer(A_TH, 32'd0, 4'b0000, 1'b1, 1'b1, 32'd0, "fetch_rd");
    xfer(A_TH, 32'd7, 4'b1111, 1'b1, 1'b0, 32'd0, "fetch_wr");
    rd(A_TH, 32'd3, "th_after_fetch");

    // Reset during a claim acceptance cycle
    @(negedge clk);
    irq_src   = 8'h00;
    mem_valid = 1'b1;
    mem_addr  = A_CLAIM;
    mem_wstrb = 4'b0000;
    mem_instr = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready", {31'b0, mem_ready}, 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready2", {31'b0, mem_ready}, 32'd0);
    check("rst_mid_meip", {31'b0, meip}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd(A_PEND, 32'd0, "post_rst_pend");
    rd(A_EN, 32'd0, "post_rst_en");
    rd(A_TH, 32'd0, "post_rst_th");
    rd(prio_a(7), 32'd0, "post_rst_prio7");
    rd(A_CLAIM, 32'd0, "post_rst_claim");
    // Source 1 was inflight before reset; it must be able to pend again
    wr(prio_a(1), 32'd1, "post_rst_prio1");
    wr(A_EN, 32'h02, "post_rst_en1");
    @(negedge clk);
    irq_src = 8'h01;
    repeat (3) @(posedge clk);
    rd(A_PEND, 32'h02, "post_rst_inflight_clear");
    check("post_rst_meip", {31'b0, meip}, 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plic.md
Name: plic

Overview:
Platform-level interrupt controller for the single M-mode hart. It gathers NSRC external level-sensitive interrupt lines, applies per-source priority and enable plus a global threshold, and drives the core's meip input. It is memory-mapped on the peripheral bus and implements the claim/complete handshake used by the machine-mode trap handler.

Parameters:
NSRC, 8, number of interrupt sources, IDs 1..NSRC, max 31; ID 0 means "no interrupt"
PRIO_W, 3, priority/threshold width; priority 0 = source never interrupts

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
irq_src  in  NSRC  level interrupt lines; bit i-1 = source ID i
mem_valid  in  1  bus request; held until mem_ready
mem_instr  in  1  fetch flag; fetch reads return 0, writes ignored
mem_addr  in  32  byte address; block decodes [21:0]
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 = read, nonzero = full-word write (partial strobes treated as full)
mem_rdata  out  32  read data, valid with mem_ready
mem_ready  out  1  one-cycle response pulse
meip  out  1  machine external interrupt pending, to csr meip

Behaviour:
- Register map (offset in mem_addr[21:0]):
  0x000000+4*id: priority[id], RW, PRIO_W bits; id 0 and id>NSRC read 0, writes ignored
  0x001000: pending word, RO; bit 0 always 0
  0x002000: enable word, RW; bit 0 and bits >NSRC hardwired 0
  0x200000: threshold, RW, PRIO_W bits
  0x200004: read = claim, write = complete
  Any other offset: reads 0, writes ignored, still acknowledged.
- Reset: priority, pending, enable, threshold, inflight, irq_q all 0; mem_ready=0; mem_rdata=0; meip=0.
- Bus: an access is accepted at the clock edge where mem_valid=1 and mem_ready=0. mem_ready=1 for exactly one cycle after acceptance, with mem_rdata valid. No acceptance while mem_ready=1. mem_rdata=0 whenever mem_ready=0.
- Gateway: irq_src is registered into irq_q, giving one cycle of latency.
  - pending[i] is set at an edge where irq_q[i]=1, pending[i]=0 and inflight[i]=0.
  - Otherwise pending[i] holds until claimed. Deasserting irq_src does not clear pending.
- Arbiter (combinational, from registered state):
  - Candidate = pending & enable & (priority > threshold).
  - best_id = candidate with highest priority; ties go to the lowest ID; 0 if none.
  - max_prio = priority of best_id.
- meip register: next value = (best_id != 0). irq_src rise to meip=1 takes 3 edges: irq_q, pending, meip.
- Claim read:
  - mem_rdata = best_id evaluated at acceptance.
  - If nonzero, pending[best_id] is cleared and inflight[best_id] is set at that edge.
  - Claim returning 0 changes no state.
- Complete write:
  - id = mem_wdata[4:0]. If 1 <= id <= NSRC and inflight[id]=1, inflight[id] is cleared.
  - Otherwise the write is ignored.
  - The source may re-pend on the next edge if irq_q is still 1.
- Simultaneous events:
  - Claim and gateway set for the same ID on the same edge: claim wins, leaving pending=0 and inflight=1.
  - A priority/enable/threshold write on the same edge as an arbiter evaluation: the arbiter uses the old values; the new values take effect the next cycle.
  - meip may stay 1 for one cycle after a claim. The handler must tolerate a claim returning 0.
- Reset asserted mid-access: the access is dropped, mem_ready=0 on the next cycle, and all state returns to reset values.

Decomposition:
- Shared package (constants/wires):
  - plic offset constants.
  - plic_in_type / plic_out_type bundling the bus signals.
  - plic_reg_type: priority array, pending, enable, threshold, inflight.
  - init_plic_reg.
- Sub-module plic_arbiter: combinational tree over priority/candidate, outputs best_id and max_prio; parameterised by NSRC and PRIO_W.
- Top level holds registers, gateway, bus FSM (IDLE/RESP) and the meip register.

Test Plan:
- Reset, then read all registers → all 0; meip=0; each access gets exactly one mem_ready pulse, one cycle after acceptance.
- priority[3]=2, enable=0x8, threshold=1, then pulse irq_src[2] high for 1 cycle → meip=1 3 edges after the rise; claim returns 3; pending bit 3 clears; meip=0 within 2 cycles.
- Sources 2 and 5 both priority 4, source 6 priority 4, all enabled → claims return 2, then 5, then 6, then 0. While 2 is held high and not completed, it does not re-pend.
- Threshold=4 with priority[1]=4 pending and enabled → meip=0. Write threshold=3 → meip=1 two cycles later.
- Complete with id 0, id 9 and id 4 (not inflight) → no state change. Complete with id 2 while its line is still high → pending[2]=1 on the next edge.
- Assert rst during a claim acceptance cycle → no mem_ready; pending/inflight/enable all 0 after reset.
